// File: rtl/music_pkg.sv
// Shared types and helpers for the auto-play music scheduler.
package music_pkg;

    localparam int unsigned NOTE_W = 5;

    typedef logic [NOTE_W-1:0] note_t;

    localparam note_t NOTE_REST = 5'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w += 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/music_scheduler_beat_timer.sv
// Beat timer: divides clk by TICK_DIV and pulses tick_o on the last count.
// The counter only advances while enabled; clear has priority over enable.
module beat_timer
    import music_pkg::*;
#(
    parameter int unsigned TICK_DIV = 6250000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = width_of(TICK_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign tick_o = en_i && !clr_i && at_max;

    // Next count: clear, wrap at the last count, or hold when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/music_scheduler.sv
// Auto-play music sequencer: picks a song ROM, steps its beat index on the
// beat tick, handles play/pause/skip/abort and registers the note for the
// tone generator.
// Optional feature macro: SCHED_LOOP_EN (defined: playlist loops back to
// song 0 after the last song's gap; undefined: stops in DONE).
module music_scheduler
    import music_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 6250000,
    parameter int unsigned SONG_LEN  = 128,
    parameter int unsigned NUM_SONGS = 4,
    parameter int unsigned GAP_BEATS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               play,
    input  logic                               pause,
    input  logic                               next_song,
    input  logic                               over,
    input  note_t                              note_in,
    output logic [width_of(NUM_SONGS)-1:0]     song_sel,
    output logic [width_of(SONG_LEN)-1:0]      beat_idx,
    output note_t                              note_out,
    output logic                               beat_tick,
    output logic                               get_pause,
    output logic                               get_return
);

    localparam int unsigned SEL_W = width_of(NUM_SONGS);
    localparam int unsigned IDX_W = width_of(SONG_LEN);
    localparam int unsigned GAP_W = width_of(GAP_BEATS);

    localparam logic [SEL_W-1:0] LAST_SONG = SEL_W'(NUM_SONGS - 1);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(SONG_LEN - 1);
    localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(GAP_BEATS - 1);

    sched_state_t     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    note_t            note_q, note_d;
    logic             pause_q, pause_d;
    logic             ret_q;

    logic             skip;
    logic             start;
    logic             timer_en;
    logic             timer_clr;
    logic             tick;
    logic [SEL_W-1:0] sel_inc;

    // Skip is honoured everywhere except IDLE; a start pulse only from IDLE/DONE.
    assign skip    = next_song && (state_q != IDLE);
    assign start   = play && ((state_q == IDLE) || (state_q == DONE));
    assign sel_inc = (sel_q == LAST_SONG) ? '0 : sel_q + SEL_W'(1);

    // Timer runs in PLAY (unless pausing) and GAP; restarts on abort, skip or start.
    assign timer_clr = over || skip || start;
    assign timer_en  = !over && !skip
                     && ((state_q == GAP) || ((state_q == PLAY) && !pause));

    beat_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_beat_timer (
        .clk    (clk),
        .rst    (rst),
        .en_i   (timer_en),
        .clr_i  (timer_clr),
        .tick_o (tick)
    );

    // Next-state, index and note logic in priority order over > skip > pause > play > tick.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        gap_d   = gap_q;

        if (over) begin
            state_d = IDLE;
            sel_d   = '0;
            idx_d   = '0;
            gap_d   = '0;
        end else if (skip) begin
            state_d = pause ? PAUSE : PLAY;
            sel_d   = sel_inc;
            idx_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (play) begin
                        state_d = pause ? PAUSE : PLAY;
                        sel_d   = '0;
                        idx_d   = '0;
                        gap_d   = '0;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (idx_q == LAST_BEAT) begin
                            state_d = GAP;
                            idx_d   = '0;
                            gap_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_d = PLAY;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_q == LAST_GAP) begin
                            gap_d = '0;
                            if (sel_q == LAST_SONG) begin
`ifdef SCHED_LOOP_EN
                                sel_d   = '0;
                                state_d = PLAY;
`else
                                state_d = DONE;
`endif
                            end else begin
                                sel_d   = sel_q + SEL_W'(1);
                                state_d = PLAY;
                            end
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                    idx_d   = '0;
                    gap_d   = '0;
                end
            endcase
        end

        // Note is only forwarded while staying in PLAY; every other case is a rest.
        note_d  = ((state_q == PLAY) && (state_d == PLAY)) ? note_in : NOTE_REST;
        pause_d = (state_d == PAUSE);
    end

    // State, index, note and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            note_q  <= NOTE_REST;
            pause_q <= 1'b0;
            ret_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            note_q  <= note_d;
            pause_q <= pause_d;
            ret_q   <= over;
        end
    end

    assign song_sel   = sel_q;
    assign beat_idx   = idx_q;
    assign note_out   = note_q;
    assign beat_tick  = tick;
    assign get_pause  = pause_q;
    assign get_return = ret_q;

endmodule

// File: tb/tb_music_scheduler.sv
// Directed bench for music_scheduler with TICK_DIV=4, SONG_LEN=8,
// NUM_SONGS=2, GAP_BEATS=2. Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at the same point.
module tb_music_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       play;
    logic       pause;
    logic       next_song;
    logic       over;
    logic [4:0] note_in;
    logic [0:0] song_sel;
    logic [2:0] beat_idx;
    logic [4:0] note_out;
    logic       beat_tick;
    logic       get_pause;
    logic       get_return;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in ROM: every entry distinct and non-zero.
    function automatic logic [4:0] rom(input int unsigned s, input int unsigned i);
        return 5'(s * 8 + i + 1);
    endfunction

    assign note_in = rom(32'(song_sel), 32'(beat_idx));

    music_scheduler #(
        .TICK_DIV  (4),
        .SONG_LEN  (8),
        .NUM_SONGS (2),
        .GAP_BEATS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .play       (play),
        .pause      (pause),
        .next_song  (next_song),
        .over       (over),
        .note_in    (note_in),
        .song_sel   (song_sel),
        .beat_idx   (beat_idx),
        .note_out   (note_out),
        .beat_tick  (beat_tick),
        .get_pause  (get_pause),
        .get_return (get_return)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; play = 1'b0; pause = 1'b0; next_song = 1'b0; over = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks++; if (song_sel !== 1'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", song_sel); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", beat_idx); end
        checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL reset_note got %0d want 0", note_out); end
        checks++; if (beat_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0d want 0", beat_tick); end
        checks++; if (get_pause !== 1'b0) begin errors++; $display("FAIL reset_pause got %0d want 0", get_pause); end
        checks++; if (get_return !== 1'b0) begin errors++; $display("FAIL reset_return got %0d want 0", get_return); end
        // Pause in IDLE is ignored.
        pause = 1'b1;
        repeat (3) step();
        checks++; if (get_pause !== 1'b0) begin errors++; $display("FAIL idle_pause got %0d want 0", get_pause); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL idle_idx got %0d want 0", beat_idx); end
        pause = 1'b0;
        step();
    endtask

    task automatic test_play();
        play = 1'b1;
        step();
        play = 1'b0;
        checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL play_first_note got %0d want 0", note_out); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (beat_idx !== 3'(k)) begin errors++; $display("FAIL play_idx got %0d want %0d", beat_idx, k); end
            checks++; if (song_sel !== 1'd0) begin errors++; $display("FAIL play_sel got %0d want 0", song_sel); end
            step();
            checks++; if (note_out !== rom(0, k)) begin errors++; $display("FAIL play_note got %0d want %0d", note_out, rom(0, k)); end
            checks++; if (beat_tick !== 1'b0) begin errors++; $display("FAIL play_notick got %0d want 0", beat_tick); end
            step();
            step();
            checks++; if (beat_tick !== 1'b1) begin errors++; $display("FAIL play_tick got %0d want 1", beat_tick); end
            step();
        end
    endtask

    task automatic test_pause();
        step();
        checks++; if (beat_idx !== 3'd3) begin errors++; $display("FAIL pre_pause_idx got %0d want 3", beat_idx); end
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (get_pause !== 1'b1) begin errors++; $display("FAIL pause_flag got %0d want 1", get_pause); end
            checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL pause_note got %0d want 0", note_out); end
            checks++; if (beat_idx !== 3'd3) begin errors++; $display("FAIL pause_idx got %0d want 3", beat_idx); end
            checks++; if (beat_tick !== 1'b0) begin errors++; $display("FAIL pause_tick got %0d want 0", beat_tick); end
        end
        pause = 1'b0;
        step();
        checks++; if (get_pause !== 1'b0) begin errors++; $display("FAIL resume_flag got %0d want 0", get_pause); end
        checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL resume_note0 got %0d want 0", note_out); end
        step();
        checks++; if (note_out !== rom(0, 3)) begin errors++; $display("FAIL resume_note got %0d want %0d", note_out, rom(0, 3)); end
        step();
        checks++; if (beat_tick !== 1'b1) begin errors++; $display("FAIL resume_tick got %0d want 1", beat_tick); end
        checks++; if (beat_idx !== 3'd3) begin errors++; $display("FAIL resume_idx3 got %0d want 3", beat_idx); end
        step();
        checks++; if (beat_idx !== 3'd4) begin errors++; $display("FAIL resume_idx4 got %0d want 4", beat_idx); end
    endtask

    task automatic test_gap();
        repeat (16) step();
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL gap_idx got %0d want 0", beat_idx); end
        for (int i = 0; i < 8; i++) begin
            if (i != 0) step();
            checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL gap_note got %0d want 0", note_out); end
            checks++; if (song_sel !== 1'd0) begin errors++; $display("FAIL gap_sel got %0d want 0", song_sel); end
        end
        step();
        checks++; if (song_sel !== 1'd1) begin errors++; $display("FAIL gap_next_sel got %0d want 1", song_sel); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL gap_next_idx got %0d want 0", beat_idx); end
        step();
        checks++; if (note_out !== rom(1, 0)) begin errors++; $display("FAIL song1_note got %0d want %0d", note_out, rom(1, 0)); end
    endtask

    task automatic test_next_song();
        repeat (21) step();
        checks++; if (beat_idx !== 3'd5) begin errors++; $display("FAIL skip_pre_idx got %0d want 5", beat_idx); end
        checks++; if (song_sel !== 1'd1) begin errors++; $display("FAIL skip_pre_sel got %0d want 1", song_sel); end
        next_song = 1'b1;
        step();
        next_song = 1'b0;
        checks++; if (song_sel !== 1'd0) begin errors++; $display("FAIL skip_sel got %0d want 0", song_sel); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL skip_idx got %0d want 0", beat_idx); end
        repeat (3) step();
        checks++; if (beat_tick !== 1'b1) begin errors++; $display("FAIL skip_tick got %0d want 1", beat_tick); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL skip_idx_hold got %0d want 0", beat_idx); end
        step();
        checks++; if (beat_idx !== 3'd1) begin errors++; $display("FAIL skip_idx1 got %0d want 1", beat_idx); end
    endtask

    task automatic test_end();
        repeat (75) step();
        checks++; if (song_sel !== 1'd1) begin errors++; $display("FAIL end_gap_sel got %0d want 1", song_sel); end
        checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL end_gap_note got %0d want 0", note_out); end
        step();
`ifdef SCHED_LOOP_EN
        checks++; if (song_sel !== 1'd0) begin errors++; $display("FAIL loop_sel got %0d want 0", song_sel); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL loop_idx got %0d want 0", beat_idx); end
        repeat (4) step();
        checks++; if (beat_idx !== 3'd1) begin errors++; $display("FAIL loop_idx1 got %0d want 1", beat_idx); end
`else
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (song_sel !== 1'd1) begin errors++; $display("FAIL done_sel got %0d want 1", song_sel); end
            checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL done_idx got %0d want 0", beat_idx); end
            checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL done_note got %0d want 0", note_out); end
            checks++; if (beat_tick !== 1'b0) begin errors++; $display("FAIL done_tick got %0d want 0", beat_tick); end
            step();
        end
        checks++; if (get_pause !== 1'b0) begin errors++; $display("FAIL done_pause got %0d want 0", get_pause); end
        pause = 1'b0;
`endif
    endtask

    task automatic test_over();
        play = 1'b1;
        step();
        play = 1'b0;
        repeat (5) step();
        over = 1'b1;
        play = 1'b1;
        step();
        play = 1'b0;
        checks++; if (get_return !== 1'b1) begin errors++; $display("FAIL over_return got %0d want 1", get_return); end
        checks++; if (song_sel !== 1'd0) begin errors++; $display("FAIL over_sel got %0d want 0", song_sel); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL over_idx got %0d want 0", beat_idx); end
        checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL over_note got %0d want 0", note_out); end
        repeat (2) step();
        checks++; if (get_return !== 1'b1) begin errors++; $display("FAIL over_hold got %0d want 1", get_return); end
        over = 1'b0;
        step();
        checks++; if (get_return !== 1'b0) begin errors++; $display("FAIL over_release got %0d want 0", get_return); end
        repeat (6) step();
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL idle_after_over_idx got %0d want 0", beat_idx); end
        checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL idle_after_over_note got %0d want 0", note_out); end
        checks++; if (beat_tick !== 1'b0) begin errors++; $display("FAIL idle_after_over_tick got %0d want 0", beat_tick); end
    endtask

    task automatic test_back_to_back();
        play = 1'b1;
        step();
        play = 1'b0;
        repeat (5) step();
        checks++; if (beat_idx !== 3'd1) begin errors++; $display("FAIL b2b_pre_idx got %0d want 1", beat_idx); end
        next_song = 1'b1; pause = 1'b1; play = 1'b1;
        step();
        next_song = 1'b0; play = 1'b0;
        checks++; if (song_sel !== 1'd1) begin errors++; $display("FAIL b2b_sel got %0d want 1", song_sel); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL b2b_idx got %0d want 0", beat_idx); end
        checks++; if (get_pause !== 1'b1) begin errors++; $display("FAIL b2b_pause got %0d want 1", get_pause); end
        checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL b2b_note got %0d want 0", note_out); end
        repeat (3) step();
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL b2b_hold_idx got %0d want 0", beat_idx); end
        pause = 1'b0;
        step();
        checks++; if (get_pause !== 1'b0) begin errors++; $display("FAIL b2b_resume got %0d want 0", get_pause); end
        repeat (3) step();
        checks++; if (beat_tick !== 1'b1) begin errors++; $display("FAIL b2b_tick got %0d want 1", beat_tick); end
        step();
        checks++; if (beat_idx !== 3'd1) begin errors++; $display("FAIL b2b_idx1 got %0d want 1", beat_idx); end
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (song_sel !== 1'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", song_sel); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got %0d want 0", beat_idx); end
        checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL rst_note got %0d want 0", note_out); end
        checks++; if (get_pause !== 1'b0) begin errors++; $display("FAIL rst_pause got %0d want 0", get_pause); end
        checks++; if (beat_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %0d want 0", beat_tick); end
        repeat (4) step();
        checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL rst_quiet got %0d want 0", note_out); end
        // Play and pause together from IDLE lands in PAUSE at beat 0.
        play = 1'b1; pause = 1'b1;
        step();
        play = 1'b0;
        checks++; if (get_pause !== 1'b1) begin errors++; $display("FAIL pp_pause got %0d want 1", get_pause); end
        checks++; if (beat_idx !== 3'd0) begin errors++; $display("FAIL pp_idx got %0d want 0", beat_idx); end
        pause = 1'b0;
        step();
        checks++; if (get_pause !== 1'b0) begin errors++; $display("FAIL pp_resume got %0d want 0", get_pause); end
        repeat (4) step();
        checks++; if (beat_idx !== 3'd1) begin errors++; $display("FAIL pp_idx1 got %0d want 1", beat_idx); end
    endtask

    initial begin
        rst = 1'b1; play = 1'b0; pause = 1'b0; next_song = 1'b0; over = 1'b0;
        test_reset();
        test_play();
        test_pause();
        test_gap();
        test_next_song();
        test_end();
        test_over();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
